// File: rtl/down_counter.sv
// Loadable down-counter for one egg-timer digit: decrements on enable and wraps 0 -> MAX.
// Define DOWN_COUNTER_BORROW_EN to add the borrow output used to chain digit stages.
module down_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] start_count,
  output logic [WIDTH-1:0] count,
`ifdef DOWN_COUNTER_BORROW_EN
  output logic             zero_count,
  output logic             borrow
`else
  output logic             zero_count
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_next_dec;
  logic             w_zero;

  // Clamp the programmed value so the register never holds an illegal digit.
  assign w_load     = (start_count > MAX_V) ? MAX_V : start_count;
  assign w_zero     = (r_count == '0);
  assign w_next_dec = w_zero ? MAX_V : (r_count - ONE_V);

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= w_load;
    else if (enable)
      r_count <= w_next_dec;
  end

  assign count      = r_count;
  assign zero_count = w_zero;

`ifdef DOWN_COUNTER_BORROW_EN
  // Fires on the tick that wraps this digit, so the next stage decrements on the same edge.
  assign borrow = enable & w_zero & ~reset;
`endif

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_down_counter;
  localparam int WIDTH = 4;
  localparam int MAX   = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] start_count = '0;
  logic [WIDTH-1:0] count;
  logic             zero_count;
`ifdef DOWN_COUNTER_BORROW_EN
  logic             borrow;
`endif

  int n_chk = 0;
  int n_err = 0;
  int m_count = 0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start_count (start_count),
    .count       (count),
`ifdef DOWN_COUNTER_BORROW_EN
    .zero_count  (zero_count),
    .borrow      (borrow)
`else
    .zero_count  (zero_count)
`endif
  );

  // Advance one clock and update the reference model from the inputs seen at that edge.
  task automatic step();
    @(posedge clk);
    if (reset)       m_count = (int'(start_count) > MAX) ? MAX : int'(start_count);
    else if (enable) m_count = (m_count == 0) ? MAX : m_count - 1;
    #1;
  endtask

  task automatic test_reset();
    start_count = 4'd9; reset = 1'b1; enable = 1'b0;
    step();
    reset = 1'b0;
    n_chk++; if (count !== 4'd9) begin n_err++; $display("FAIL reset_count got %0d want 9", count); end
    n_chk++; if (zero_count !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b want 0", zero_count); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 20; i++) step();
    n_chk++; if (count !== 4'd9) begin n_err++; $display("FAIL hold_count got %0d want 9", count); end
  endtask

  task automatic test_ticks();
    for (int k = 8; k >= 0; k--) begin
      enable = 1'b1;
      step();
      enable = 1'b0;
      n_chk++; if (int'(count) !== k) begin n_err++; $display("FAIL tick_count got %0d want %0d", count, k); end
      n_chk++; if (zero_count !== (k == 0)) begin n_err++; $display("FAIL tick_zero got %b want %b", zero_count, (k == 0)); end
      for (int j = 0; j < 9; j++) begin
        step();
        if (int'(count) !== k) begin n_chk++; n_err++; $display("FAIL tick_idle got %0d want %0d", count, k); end
      end
    end
  endtask

  task automatic test_wrap();
    enable = 1'b1;
`ifdef DOWN_COUNTER_BORROW_EN
    #1;
    n_chk++; if (borrow !== 1'b1) begin n_err++; $display("FAIL wrap_borrow got %b want 1", borrow); end
`endif
    step();
    enable = 1'b0;
    n_chk++; if (count !== 4'd9) begin n_err++; $display("FAIL wrap_count got %0d want 9", count); end
    n_chk++; if (zero_count !== 1'b0) begin n_err++; $display("FAIL wrap_zero got %b want 0", zero_count); end
`ifdef DOWN_COUNTER_BORROW_EN
    #1;
    n_chk++; if (borrow !== 1'b0) begin n_err++; $display("FAIL wrap_borrow_after got %b want 0", borrow); end
`endif
  endtask

  task automatic test_continuous();
    int exp_seq[12] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8, 7};
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++; if (int'(count) !== exp_seq[i]) begin n_err++; $display("FAIL cont_count[%0d] got %0d want %0d", i, count, exp_seq[i]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_clamp();
    start_count = 4'd12; reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++; if (count !== 4'd9) begin n_err++; $display("FAIL clamp_count got %0d want 9", count); end
    start_count = 4'd0; reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++; if (count !== 4'd0) begin n_err++; $display("FAIL load0_count got %0d want 0", count); end
    n_chk++; if (zero_count !== 1'b1) begin n_err++; $display("FAIL load0_zero got %b want 1", zero_count); end
  endtask

  task automatic test_priority();
    start_count = 4'd4; reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++; if (count !== 4'd4) begin n_err++; $display("FAIL prio_setup got %0d want 4", count); end
    start_count = 4'd9; reset = 1'b1; enable = 1'b1;
`ifdef DOWN_COUNTER_BORROW_EN
    #1;
    n_chk++; if (borrow !== 1'b0) begin n_err++; $display("FAIL prio_borrow got %b want 0", borrow); end
`endif
    step();
    reset = 1'b0; enable = 1'b0;
    n_chk++; if (count !== 4'd9) begin n_err++; $display("FAIL prio_count got %0d want 9", count); end
  endtask

  task automatic test_start_ignored();
    start_count = 4'd3;
    for (int i = 0; i < 3; i++) step();
    n_chk++; if (count !== 4'd9) begin n_err++; $display("FAIL start_ign_hold got %0d want 9", count); end
    enable = 1'b1;
    step();
    enable = 1'b0;
    n_chk++; if (count !== 4'd8) begin n_err++; $display("FAIL start_ign_dec got %0d want 8", count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(15) == 0);
      enable      = ($urandom_range(1) == 1);
      start_count = WIDTH'($urandom_range(15));
`ifdef DOWN_COUNTER_BORROW_EN
      #1;
      n_chk++;
      if (borrow !== (enable && !reset && m_count == 0)) begin
        n_err++; $display("FAIL rand_borrow[%0d] got %b want %b", i, borrow, (enable && !reset && m_count == 0));
      end
`endif
      step();
      n_chk++; if (int'(count) !== m_count) begin n_err++; $display("FAIL rand_count[%0d] got %0d want %0d", i, count, m_count); end
      n_chk++; if (zero_count !== (m_count == 0)) begin n_err++; $display("FAIL rand_zero[%0d] got %b want %b", i, zero_count, (m_count == 0)); end
    end
    reset = 1'b0; enable = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_hold();
    test_ticks();
    test_wrap();
    test_continuous();
    test_clamp();
    test_priority();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
